// File: rtl/hex_effect_pkg.sv
// Shared types and constants for the HEX display effect sequencer.
// Glyph table rows 10-15 are only reachable when HEX_EFFECT_HEX_EN is defined.
package hex_effect_pkg;

    typedef enum logic [2:0] {
        FX_STATIC    = 3'd0,
        FX_BLINK     = 3'd1,
        FX_SCROLL_L  = 3'd2,
        FX_SCROLL_R  = 3'd3,
        FX_STACK     = 3'd4,
        FX_BOUNCE    = 3'd5,
        FX_COUNTDOWN = 3'd6,
        FX_ALT       = 3'd7
    } effect_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns for 0-9 followed by A b C d E F.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_effect_engine_seg7_encode.sv
// Combinational 4-bit to active-low 7-segment encoder.
// HEX_EFFECT_HEX_EN selects A-F glyphs for 10-15; otherwise those values render blank.
module seg7_encode
    import hex_effect_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

`ifdef HEX_EFFECT_HEX_EN
    assign seg = GLYPH_TABLE[value];
`else
    assign seg = (value > 4'd9) ? SEG_BLANK : GLYPH_TABLE[value];
`endif

endmodule

// File: rtl/hex_effect_engine.sv
// Eight-effect animation sequencer driving NUM_DIGITS active-low seven-segment displays.
// Optional macro HEX_EFFECT_HEX_EN (via seg7_encode) enables A-F glyphs for values 10-15.
module hex_effect_engine
    import hex_effect_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int TICK_LOG2   = 22,
    parameter int DWELL_TICKS = 48
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    auto_i,
    input  logic [2:0]              effect_i,
    input  logic                    pause_i,
    output logic [7*NUM_DIGITS-1:0] hex_o,
    output logic [2:0]              effect_o,
    output logic                    tick_o
);

    localparam int STEP_W  = $clog2(2*NUM_DIGITS + 1);
    localparam int DWELL_W = $clog2(DWELL_TICKS + 1);

    localparam logic [STEP_W-1:0]  SCROLL_LAST = STEP_W'(NUM_DIGITS - 1);
    localparam logic [STEP_W-1:0]  STACK_LAST  = STEP_W'(NUM_DIGITS);
    localparam logic [STEP_W-1:0]  BOUNCE_LAST = STEP_W'(2*NUM_DIGITS - 1);
    localparam logic [STEP_W-1:0]  BOUNCE_TOP  = STEP_W'(NUM_DIGITS);
    localparam logic [STEP_W-1:0]  BOUNCE_SPAN = STEP_W'(2*NUM_DIGITS);
    localparam logic [STEP_W-1:0]  DIGIT_COUNT = STEP_W'(NUM_DIGITS);
    localparam logic [DWELL_W-1:0] DWELL_LAST  = DWELL_W'(DWELL_TICKS - 1);

    logic [TICK_LOG2-1:0]    presc;
    logic                    tick;

    effect_e                 effect_q, effect_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [DWELL_W-1:0]      dwell_q, dwell_d;
    logic [3:0]              cd_q [NUM_DIGITS];
    logic [3:0]              cd_d [NUM_DIGITS];
    logic [3:0]              digit [NUM_DIGITS];
    logic [3:0]              reload [NUM_DIGITS];
    logic                    cd_done;
    logic                    restart;
    logic                    advance;
    logic [STEP_W-1:0]       bounce_lvl;
    logic [7*NUM_DIGITS-1:0] hex_d;
    logic [7*NUM_DIGITS-1:0] hex_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc <= '0;
        end else if (!pause_i) begin
            presc <= presc + 1'b1;
        end
    end

    assign tick   = (&presc) && !pause_i;
    assign tick_o = tick;

    // Countdown reloads at 9, or at the target itself when it is above 9 so it is already done.
    always_comb begin
        cd_done = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            reload[k] = (digit[k] > 4'd9) ? digit[k] : 4'd9;
            if (cd_q[k] > digit[k]) begin
                cd_done = 1'b0;
            end
        end
    end

    // A manual change always beats a coincident tick; auto mode ignores effect_i entirely.
    always_comb begin
        effect_d = effect_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cd_d     = cd_q;
        restart  = 1'b0;
        advance  = 1'b0;

        if (!auto_i) begin
            dwell_d = '0;
            if (effect_i != effect_q) begin
                effect_d = effect_e'(effect_i);
                restart  = 1'b1;
            end else if (tick) begin
                advance = 1'b1;
            end
        end else if (tick) begin
            if (dwell_q == DWELL_LAST) begin
                effect_d = effect_e'(effect_q + 3'd1);
                dwell_d  = '0;
                restart  = 1'b1;
            end else begin
                dwell_d = dwell_q + 1'b1;
                advance = 1'b1;
            end
        end

        if (restart) begin
            step_d = '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                cd_d[k] = reload[k];
            end
        end else if (advance) begin
            unique case (effect_q)
                FX_BLINK, FX_ALT: begin
                    step_d = {{(STEP_W-1){1'b0}}, ~step_q[0]};
                end
                FX_SCROLL_L, FX_SCROLL_R: begin
                    step_d = (step_q >= SCROLL_LAST) ? '0 : step_q + 1'b1;
                end
                FX_STACK: begin
                    step_d = (step_q >= STACK_LAST) ? '0 : step_q + 1'b1;
                end
                FX_BOUNCE: begin
                    step_d = (step_q >= BOUNCE_LAST) ? '0 : step_q + 1'b1;
                end
                FX_COUNTDOWN: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (cd_done) begin
                            cd_d[k] = reload[k];
                        end else if (cd_q[k] > digit[k]) begin
                            cd_d[k] = cd_q[k] - 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            effect_q <= FX_STATIC;
            step_q   <= '0;
            dwell_q  <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                cd_q[k] <= 4'd9;
            end
            hex_q    <= '1;
        end else begin
            effect_q <= effect_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cd_q     <= cd_d;
            hex_q    <= hex_d;
        end
    end

    // Bounce phase 0..2N-1 folds into a lit count rising 0..N then falling back.
    assign bounce_lvl = (step_q <= BOUNCE_TOP) ? step_q : (BOUNCE_SPAN - step_q);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_pos
        localparam logic [STEP_W-1:0] POS = STEP_W'(k);

        logic [STEP_W-1:0] left_idx;
        logic [STEP_W-1:0] right_sum;
        logic [STEP_W-1:0] right_idx;
        logic [3:0]        value;
        logic              show;
        logic [6:0]        seg;

        assign digit[k]  = digits_i[4*k +: 4];
        assign left_idx  = (POS >= step_q) ? (POS - step_q) : (POS + DIGIT_COUNT - step_q);
        assign right_sum = POS + step_q;
        assign right_idx = (right_sum >= DIGIT_COUNT) ? (right_sum - DIGIT_COUNT) : right_sum;

        always_comb begin
            value = digit[k];
            show  = 1'b1;
            unique case (effect_q)
                FX_BLINK:     show  = ~step_q[0];
                FX_SCROLL_L: begin
                    for (int j = 0; j < NUM_DIGITS; j++) begin
                        if (left_idx == STEP_W'(j)) value = digit[j];
                    end
                end
                FX_SCROLL_R: begin
                    for (int j = 0; j < NUM_DIGITS; j++) begin
                        if (right_idx == STEP_W'(j)) value = digit[j];
                    end
                end
                FX_STACK:     show  = (POS < step_q);
                FX_BOUNCE:    show  = (POS < bounce_lvl);
                FX_COUNTDOWN: value = cd_q[k];
                FX_ALT:       show  = (POS[0] == step_q[0]);
                default: begin
                end
            endcase
        end

        seg7_encode u_enc (
            .value (value),
            .seg   (seg)
        );

        assign hex_d[7*k +: 7] = show ? seg : SEG_BLANK;
    end

    assign hex_o    = hex_q;
    assign effect_o = effect_q;

endmodule

// File: tb/tb_hex_effect_engine.sv
// Self-checking bench for hex_effect_engine against a tick-count based reference model.
// Honours HEX_EFFECT_HEX_EN when deciding how values 10-15 should render.
module tb_hex_effect_engine;

    localparam int N     = 8;
    localparam int TL2   = 2;
    localparam int DWELL = 3;
    localparam int PMAX  = (1 << TL2) - 1;

    logic          clk;
    logic          rst_n;
    logic [31:0]   digits;
    logic          auto_in;
    logic [2:0]    effect_in;
    logic          pause_in;
    logic [55:0]   hex_o;
    logic [2:0]    effect_o;
    logic          tick_o;

    int            checks;
    int            failures;

    int            m_presc;
    int            m_effect;
    int            m_dwell;
    int            m_t;
    int            m_cd [N];
    logic [55:0]   m_hex;

    hex_effect_engine #(
        .NUM_DIGITS  (N),
        .TICK_LOG2   (TL2),
        .DWELL_TICKS (DWELL)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .digits_i (digits),
        .auto_i   (auto_in),
        .effect_i (effect_in),
        .pause_i  (pause_in),
        .hex_o    (hex_o),
        .effect_o (effect_o),
        .tick_o   (tick_o)
    );

    always #5 clk = ~clk;

    function automatic int nib(input int k);
        return int'(digits[4*k +: 4]);
    endfunction

    // Segment patterns written active-high here and inverted on return.
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] on;
        case (v)
            0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
            4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
            8: on = 7'h7F;  9: on = 7'h6F;  10: on = 7'h77; 11: on = 7'h7C;
            12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; default: on = 7'h71;
        endcase
`ifndef HEX_EFFECT_HEX_EN
        if (v > 9) on = 7'h00;
`endif
        return ~on;
    endfunction

    function automatic logic [55:0] model_display();
        logic [55:0] r;
        int src, val, p;
        bit show;
        r = '1;
        for (int k = 0; k < N; k++) begin
            src  = k;
            show = 1'b1;
            case (m_effect)
                1: show = (m_t % 2 == 0);
                2: src = (k + N - (m_t % N)) % N;
                3: src = (k + m_t) % N;
                4: show = (k < (m_t % (N + 1)));
                5: begin
                    p    = m_t % (2 * N);
                    show = (k < ((p <= N) ? p : 2 * N - p));
                end
                7: show = ((k % 2) == (m_t % 2));
                default: ;
            endcase
            val = (m_effect == 6) ? m_cd[k] : nib(src);
            r[7*k +: 7] = show ? glyph(val) : 7'h7F;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_presc  = 0;
        m_effect = 0;
        m_dwell  = 0;
        m_t      = 0;
        for (int k = 0; k < N; k++) m_cd[k] = 9;
        m_hex    = '1;
    endtask

    task automatic model_restart(input int eff);
        m_effect = eff;
        m_t      = 0;
        for (int k = 0; k < N; k++) m_cd[k] = (nib(k) > 9) ? nib(k) : 9;
    endtask

    task automatic model_advance();
        bit all_done;
        m_t++;
        if (m_effect == 6) begin
            all_done = 1'b1;
            for (int k = 0; k < N; k++) if (m_cd[k] > nib(k)) all_done = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (all_done) m_cd[k] = (nib(k) > 9) ? nib(k) : 9;
                else if (m_cd[k] > nib(k)) m_cd[k]--;
            end
        end
    endtask

    task automatic model_edge();
        bit tick;
        tick  = (m_presc == PMAX) && !pause_in;
        m_hex = model_display();
        if (!pause_in) m_presc = (m_presc + 1) % (PMAX + 1);
        if (!auto_in) begin
            m_dwell = 0;
            if (int'(effect_in) != m_effect) model_restart(int'(effect_in));
            else if (tick) model_advance();
        end else if (tick) begin
            if (m_dwell == DWELL - 1) begin
                m_dwell = 0;
                model_restart((m_effect + 1) % 8);
            end else begin
                m_dwell++;
                model_advance();
            end
        end
    endtask

    task automatic check_output(input string tag);
        logic       exp_tick;
        logic [2:0] exp_eff;
        exp_tick = (m_presc == PMAX) && !pause_in && rst_n;
        exp_eff  = 3'(m_effect);
        checks++;
        assert (hex_o === m_hex) else begin
            failures++;
            $error("[TB] FAIL %s hex_o got %h expected %h", tag, hex_o, m_hex);
        end
        checks++;
        assert (effect_o === exp_eff) else begin
            failures++;
            $error("[TB] FAIL %s effect_o got %0d expected %0d", tag, effect_o, exp_eff);
        end
        checks++;
        assert (tick_o === exp_tick) else begin
            failures++;
            $error("[TB] FAIL %s tick_o got %b expected %b", tag, tick_o, exp_tick);
        end
    endtask

    task automatic apply_stimulus(input string tag);
        @(posedge clk);
        model_edge();
        #2;
        check_output(tag);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) apply_stimulus(tag);
    endtask

    initial begin
        int guard;
        int fx_list [4];
        logic [6:0] exp_a;

        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        digits    = 32'h22520473;
        auto_in   = 1'b0;
        effect_in = 3'd0;
        pause_in  = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #2;
        check_output("reset");

        rst_n = 1'b1;
        apply_stimulus("release");
        checks++;
        assert (hex_o[6:0] === 7'b0110000) else begin
            failures++;
            $error("[TB] FAIL static_digit0 got %b expected %b", hex_o[6:0], 7'b0110000);
        end
        run(6, "static");

        effect_in = 3'd2;
        run(40, "scroll_l");
        effect_in = 3'd5;
        run(80, "bounce");
        effect_in = 3'd6;
        run(60, "countdown");

        fx_list = '{1, 3, 4, 7};
        foreach (fx_list[i]) begin
            effect_in = 3'(fx_list[i]);
            run(24, "effects");
        end

        effect_in = 3'd0;
        digits[3:0] = 4'hA;
        run(2, "hex_static");
`ifdef HEX_EFFECT_HEX_EN
        exp_a = 7'h08;
`else
        exp_a = 7'h7F;
`endif
        checks++;
        assert (hex_o[6:0] === exp_a) else begin
            failures++;
            $error("[TB] FAIL hex_digit got %h expected %h", hex_o[6:0], exp_a);
        end
        effect_in = 3'd6;
        run(30, "hex_countdown");
        digits = 32'h22520473;

        effect_in = 3'd0;
        run(3, "pre_collide");
        guard = 0;
        while (!((m_presc == PMAX) && !pause_in) && guard < 16) begin
            apply_stimulus("seek_tick");
            guard++;
        end
        checks++;
        assert (guard < 16) else begin
            failures++;
            $error("[TB] FAIL seek_tick waited %0d cycles expected fewer than 16", guard);
        end
        effect_in = 3'd4;
        apply_stimulus("collide");
        checks++;
        assert (effect_o === 3'd4) else begin
            failures++;
            $error("[TB] FAIL collide_effect got %0d expected 4", effect_o);
        end
        run(20, "post_collide");

        auto_in = 1'b1;
        run(60, "auto");
        pause_in = 1'b1;
        repeat (20) begin
            apply_stimulus("pause");
            checks++;
            assert (tick_o === 1'b0) else begin
                failures++;
                $error("[TB] FAIL pause_tick got %b expected 0", tick_o);
            end
        end
        pause_in = 1'b0;
        run(20, "resume");

        auto_in   = 1'b0;
        effect_in = 3'd5;
        run(10, "pre_async");
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_output("async_reset");
        @(posedge clk);
        #2;
        check_output("reset_hold");
        rst_n = 1'b1;

        repeat (800) begin
            if ($urandom % 40 == 0) digits = $urandom;
            if ($urandom % 25 == 0) effect_in = 3'($urandom % 8);
            if ($urandom % 60 == 0) auto_in = ~auto_in;
            if ($urandom % 50 == 0) pause_in = ~pause_in;
            apply_stimulus("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
